icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller.
- Serves fetch-stage PC requests from on-chip storage.
- On a miss, holds a fetch request to the memory controller until the full 32-bit instruction returns, then fills the line and forwards the instruction.
- Lines survive a pipeline flush (rob_clear); only reset invalidates them.

Parameters:
- INDEX_BITS, 6, line-index width; the cache holds 2^INDEX_BITS lines.
- Tag width is 30-INDEX_BITS.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when 0, all state freezes
- rob_clear  in  1  pipeline flush; aborts any miss in flight
- if_req  in  1  fetch stage requests the instruction at if_pc (level)
- if_pc  in  32  request address; bits [1:0] are ignored
- if_ready  out  1  one-cycle pulse: if_ins is valid for the request
- if_ins  out  32  returned instruction
- mem_fetch  out  1  to memory controller is_fetch; held high while the miss is outstanding
- mem_addr  out  32  to memory controller fetch_addr; word-aligned miss address
- mem_back  in  1  memory controller is_back; instruction valid this cycle
- mem_ins  in  32  memory controller back_ins

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- Storage per line: valid bit, tag, 32-bit data.
- Reset (rst_in=1 at clk edge):
  - all valid bits cleared; state=IDLE
  - if_ready=0, if_ins=0, mem_fetch=0, mem_addr=0
  - tag/data contents are don't-care.
- rdy_in=0 (and no reset): no register, array or state change; outputs hold.
- rob_clear=1 (takes priority over everything except reset):
  - state<=IDLE, if_ready<=0; mem_fetch falls the next cycle.
  - The array is unchanged.
  - If mem_back is high in the same cycle, that data is discarded: no fill, no if_ready.
- States: IDLE, MISS.
- mem_fetch = (state==MISS), combinational from state only.
- IDLE:
  - A request is accepted only when if_req=1 and if_ready=0, i.e. never in the cycle a response is presented. This prevents re-serving the stale PC.
  - Hit (valid[index] and tag match):
    - next edge: if_ready<=1, if_ins<=data[index]; state stays IDLE.
    - Hit latency is 1 cycle; peak throughput is 1 instruction per 2 cycles.
  - Miss:
    - next edge: state<=MISS, mem_addr<={if_pc[31:2],2'b00}, if_ready<=0.
    - The miss PC is latched internally (index and tag).
  - No request: if_ready<=0.
- MISS:
  - mem_fetch=1; mem_addr is held stable.
  - if_pc and if_req are ignored; the fetch stage holds its PC anyway.
  - On mem_back=1:
    - line[latched index] <= {valid=1, latched tag, mem_ins}
    - if_ready<=1, if_ins<=mem_ins, state<=IDLE.
    - mem_fetch therefore drops the cycle after mem_back, before the controller re-samples is_fetch, so no duplicate fetch is issued.
  - Otherwise the cache waits indefinitely. Controller load/store priority may delay the fill arbitrarily.
- if_ready is high for exactly one cycle per served request; the fetch stage updates its PC on that edge.
- Conflict: a miss into an occupied index overwrites the old line unconditionally.
- Fill timing: the fill takes effect at the mem_back edge. A request for the same PC accepted afterwards hits.

Test Plan:
- Cold miss: reset, if_pc=0x00000010, if_req=1 -> mem_fetch=1 and mem_addr=0x00000010 from cycle 2; then mem_back=1, mem_ins=0x00500093 -> next cycle if_ready=1, if_ins=0x00500093, mem_fetch=0.
- Hit: after the cold miss, request 0x00000010 again -> if_ready=1 one cycle after acceptance, if_ins=0x00500093, mem_fetch stays 0.
- Conflict eviction (INDEX_BITS=6): fill 0x00000010, then fill 0x00000110 (same index, different tag) -> miss with mem_addr=0x00000110. Re-requesting 0x00000010 -> miss again.
- Flush mid-miss: miss on 0x00000020, assert rob_clear for one cycle while mem_fetch=1 -> mem_fetch=0 next cycle, no if_ready. A late mem_back pulse in the rob_clear cycle produces no fill, and a later request to 0x00000020 misses. Previously filled 0x00000010 still hits.
- Stall: during MISS, drop rdy_in for 3 cycles with mem_back=1 held -> no fill, no if_ready, state and outputs frozen. Raising rdy_in with mem_back=1 -> fill and if_ready pulse.
- Back-to-back: hold if_req=1 with the PC advancing by 4 on each if_ready, over 4 cached words -> if_ready pulses every other cycle, each with the correct word and no duplicates.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch stage and the memory controller.
module icache_direct #(
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic        if_ready,
   output logic [31:0] if_ins,
   output logic        mem_fetch,
   output logic [31:0] mem_addr,
   input  logic        mem_back,
   input  logic [31:0] mem_ins
);

   localparam int unsigned LINES    = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  ready_d;
   logic [31:0]           ins_d;
   logic [31:0]           addr_d;
   logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
   logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
   logic                  fill_en;

   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [31:0]           data_mem [LINES];

   logic [INDEX_BITS-1:0] req_idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic                  req_hit;

   // Split the request PC and look it up in the array.
   assign req_idx   = if_pc[INDEX_BITS+1:2];
   assign req_tag   = if_pc[31:INDEX_BITS+2];
   assign req_hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign mem_fetch = (state_q == MISS);

   // Next-state and next-output logic; flush overrides all other activity.
   always_comb begin
      state_d    = state_q;
      ready_d    = 1'b0;
      ins_d      = if_ins;
      addr_d     = mem_addr;
      miss_idx_d = miss_idx_q;
      miss_tag_d = miss_tag_q;
      fill_en    = 1'b0;
      if (rob_clear) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Never accept while a response is presented, so a stale PC is not served twice.
               if (if_req && !if_ready) begin
                  if (req_hit) begin
                     ready_d = 1'b1;
                     ins_d   = data_mem[req_idx];
                  end else begin
                     state_d    = MISS;
                     addr_d     = {if_pc[31:2], 2'b00};
                     miss_idx_d = req_idx;
                     miss_tag_d = req_tag;
                  end
               end
            end
            MISS: begin
               if (mem_back) begin
                  fill_en = 1'b1;
                  ready_d = 1'b1;
                  ins_d   = mem_ins;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control registers and valid bits; frozen while rdy_in is low.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         if_ready   <= 1'b0;
         if_ins     <= 32'h0;
         mem_addr   <= 32'h0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
         valid_q    <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         if_ready   <= ready_d;
         if_ins     <= ins_d;
         mem_addr   <= addr_d;
         miss_idx_q <= miss_idx_d;
         miss_tag_q <= miss_tag_d;
         if (fill_en) begin
            valid_q[miss_idx_q] <= 1'b1;
         end
      end
   end

   // Tag and data storage; contents are irrelevant until the valid bit is set.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && fill_en) begin
         tag_mem[miss_idx_q]  <= miss_tag_q;
         data_mem[miss_idx_q] <= mem_ins;
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: directed fetches, monitor checks every if_ready pulse.
module tb_icache_direct;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_clear;
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_ready;
   logic [31:0] if_ins;
   logic        mem_fetch;
   logic [31:0] mem_addr;
   logic        mem_back;
   logic [31:0] mem_ins;

   int          tests  = 0;
   int          fails  = 0;
   logic [31:0] exp_q[$];

   icache_direct #(.INDEX_BITS(6)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .rob_clear(rob_clear),
      .if_req   (if_req),
      .if_pc    (if_pc),
      .if_ready (if_ready),
      .if_ins   (if_ins),
      .mem_fetch(mem_fetch),
      .mem_addr (mem_addr),
      .mem_back (mem_back),
      .mem_ins  (mem_ins)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every if_ready pulse must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk_in);
         if (!rst_in && if_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_ready: got if_ins %h expected no response", if_ins);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (if_ins !== e) begin
                  fails++;
                  $display("FAIL response: got %h expected %h", if_ins, e);
               end
            end
         end
      end
   end

   // Request pc, expect a miss, return ins from memory, expect the forwarded word.
   task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] ins);
      if_pc  = pc;
      if_req = 1'b1;
      tick();
      if_req = 1'b0;
      check("miss_fetch", 32'(mem_fetch), 32'd1);
      check("miss_addr", mem_addr, {pc[31:2], 2'b00});
      exp_q.push_back(ins);
      mem_back = 1'b1;
      mem_ins  = ins;
      tick();
      mem_back = 1'b0;
      check("fill_ready", 32'(if_ready), 32'd1);
      check("fill_fetch_drop", 32'(mem_fetch), 32'd0);
      tick();
   endtask

   // Request pc, expect a one-cycle hit with ins.
   task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] ins);
      if_pc  = pc;
      if_req = 1'b1;
      exp_q.push_back(ins);
      tick();
      if_req = 1'b0;
      check("hit_ready", 32'(if_ready), 32'd1);
      check("hit_no_fetch", 32'(mem_fetch), 32'd0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses;
      int pulse_at [4];
      rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; if_req = 1'b0;
      if_pc = 32'h0; mem_back = 1'b0; mem_ins = 32'h0;
      tick(); tick();
      rst_in = 1'b0;
      check("rst_ready", 32'(if_ready), 32'd0);
      check("rst_ins", if_ins, 32'h0);
      check("rst_fetch", 32'(mem_fetch), 32'd0);
      check("rst_addr", mem_addr, 32'h0);

      // Cold miss then hit on the same word.
      fetch_miss(32'h0000_0010, 32'h0050_0093);
      fetch_hit(32'h0000_0010, 32'h0050_0093);

      // Conflict at index 4: 0x110 evicts 0x10, which then misses again.
      fetch_miss(32'h0000_0110, 32'h1111_0013);
      fetch_hit(32'h0000_0110, 32'h1111_0013);
      fetch_miss(32'h0000_0010, 32'h0050_0093);

      // Flush mid-miss with a coincident mem_back: no fill, no response.
      if_pc = 32'h0000_0020; if_req = 1'b1;
      tick();
      if_req = 1'b0;
      check("flush_pre_fetch", 32'(mem_fetch), 32'd1);
      rob_clear = 1'b1; mem_back = 1'b1; mem_ins = 32'hDEAD_BEEF;
      tick();
      rob_clear = 1'b0; mem_back = 1'b0;
      check("flush_fetch_drop", 32'(mem_fetch), 32'd0);
      check("flush_no_ready", 32'(if_ready), 32'd0);
      tick();
      fetch_hit(32'h0000_0010, 32'h0050_0093);
      fetch_miss(32'h0000_0020, 32'h0020_0113);

      // Stall during a miss with mem_back held.
      if_pc = 32'h0000_0030; if_req = 1'b1;
      tick();
      if_req = 1'b0;
      mem_back = 1'b1; mem_ins = 32'h0030_0193; rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_fetch", 32'(mem_fetch), 32'd1);
         check("stall_ready", 32'(if_ready), 32'd0);
         check("stall_addr", mem_addr, 32'h0000_0030);
      end
      exp_q.push_back(32'h0030_0193);
      rdy_in = 1'b1;
      tick();
      mem_back = 1'b0;
      check("stall_release_ready", 32'(if_ready), 32'd1);
      check("stall_release_fetch", 32'(mem_fetch), 32'd0);
      tick();
      fetch_hit(32'h0000_0030, 32'h0030_0193);

      // Back-to-back hits over four cached words.
      for (int i = 0; i < 4; i++) fetch_miss(32'h40 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
      if_pc = 32'h40; if_req = 1'b1; pulses = 0;
      for (int c = 1; c <= 12 && if_req; c++) begin
         tick();
         check("b2b_no_fetch", 32'(mem_fetch), 32'd0);
         if (if_ready) begin
            pulse_at[pulses] = c;
            pulses++;
            if_pc = if_pc + 32'd4;
            if (if_pc == 32'h50) if_req = 1'b0;
         end
      end
      if_req = 1'b0;
      check("b2b_count", 32'(pulses), 32'd4);
      for (int i = 0; i < pulses && i < 4; i++) check("b2b_timing", 32'(pulse_at[i]), 32'(2 * i + 1));
      tick(); tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
